// File: rtl/mat_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mat_mult_ctrl
//  Purpose  : Sequences an 8x8 unsigned matrix product C = A x B. A and B are
//             read from two synchronous-read RAMs, one element pair per cycle.
//             Each C element is accumulated over k = 0..7 and then written to
//             the C RAM. A full run takes 640 cycles and ends with a one-cycle
//             done pulse.
//  Ports    : clk     - rising-edge clock, shared with the A/B/C RAMs
//             reset   - synchronous, active-high reset
//             start   - single-cycle request; only honoured in IDLE
//             addr_a  - A RAM read address {row, col}
//             data_a  - A RAM read data, one cycle after addr_a
//             addr_b  - B RAM read address {row, col}
//             data_b  - B RAM read data, one cycle after addr_b
//             addr_c  - C RAM write address {row, col}
//             mdi_c   - C RAM write data (2*DW+3 bits)
//             mwr_c   - C RAM write enable
//             busy    - high while a computation is in progress
//             done    - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module mat_mult_ctrl #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [5:0]      addr_a,
  input  logic [DW-1:0]   data_a,
  output logic [5:0]      addr_b,
  input  logic [DW-1:0]   data_b,
  output logic [5:0]      addr_c,
  output logic [2*DW+2:0] mdi_c,
  output logic            mwr_c,
  output logic            busy,
  output logic            done
);

  // Eight products of two DW-bit values need three extra bits beyond 2*DW.
  localparam int CW = 2*DW + 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LAST  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    i, i_nxt;
  logic [2:0]    j, j_nxt;
  logic [2:0]    k, k_nxt;
  logic [CW-1:0] acc, acc_nxt;
  logic [CW-1:0] prod;

  // Widen the operands before multiplying so the product is not truncated.
  assign prod = {{(CW-DW){1'b0}}, data_a} * {{(CW-DW){1'b0}}, data_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= 3'd0;
      j     <= 3'd0;
      k     <= 3'd0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      i     <= i_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
      acc   <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    k_nxt     = k;
    acc_nxt   = acc;
    addr_a    = {i, k};
    addr_b    = {k, j};
    addr_c    = {i, j};
    mdi_c     = acc;
    mwr_c     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          i_nxt     = 3'd0;
          j_nxt     = 3'd0;
          k_nxt     = 3'd0;
          state_nxt = READ;
        end
      end

      READ: begin
        busy = 1'b1;
        // RAM data lags the address by one cycle: at k the data bus holds
        // the operands for k-1, and at k=0 it holds nothing useful.
        if (k == 3'd0) begin
          acc_nxt = '0;
        end else begin
          acc_nxt = acc + prod;
        end
        k_nxt = k + 3'd1;
        if (k == 3'd7) begin
          state_nxt = LAST;
        end
      end

      LAST: begin
        busy      = 1'b1;
        // Pick up the k=7 product still in flight from the last READ cycle.
        acc_nxt   = acc + prod;
        state_nxt = WRITE;
      end

      WRITE: begin
        busy  = 1'b1;
        mwr_c = 1'b1;
        j_nxt = j + 3'd1;
        k_nxt = 3'd0;
        if (j == 3'd7) begin
          i_nxt = i + 3'd1;
        end
        if ((i == 3'd7) && (j == 3'd7)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = READ;
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mat_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mat_mult_ctrl
//  Purpose  : Self-checking bench for mat_mult_ctrl. Models the A/B RAMs,
//             captures every C write and checks it against a plain
//             triple-loop matrix product plus the expected write timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mat_mult_ctrl;

  localparam int DW = 8;
  localparam int CW = 2*DW + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [5:0]    addr_a, addr_b, addr_c;
  logic [DW-1:0] data_a, data_b;
  logic [CW-1:0] mdi_c;
  logic          mwr_c, busy, done;

  mat_mult_ctrl #(.DW(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .addr_a (addr_a),
    .data_a (data_a),
    .addr_b (addr_b),
    .data_b (data_b),
    .addr_c (addr_c),
    .mdi_c  (mdi_c),
    .mwr_c  (mwr_c),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] mem_b [64];
  int            model_c [64];

  // Synchronous-read source RAMs.
  always @(posedge clk) begin
    data_a <= mem_a[addr_a];
    data_b <= mem_b[addr_b];
  end

  int edge_cnt = 0;
  int e0       = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Capture of C writes and status, relative to the start-sampling edge.
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_rel_q[$];
  int done_cnt = 0;
  int done_rel = -1;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (mwr_c === 1'b1) begin
      wr_addr_q.push_back(int'(addr_c));
      wr_data_q.push_back(int'(mdi_c));
      wr_rel_q.push_back(edge_cnt - e0);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_rel = edge_cnt - e0;
    end
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Fill the RAMs and compute the reference product with plain arithmetic.
  task automatic load(input int kind);
    for (int idx = 0; idx < 64; idx++) begin
      int r, c;
      r = idx / 8;
      c = idx % 8;
      case (kind)
        0: begin mem_a[idx] = (r == c) ? 8'd1 : 8'd0; mem_b[idx] = 8'(idx); end
        1: begin mem_a[idx] = 8'd255; mem_b[idx] = 8'd255; end
        2: begin mem_a[idx] = 8'd1;   mem_b[idx] = 8'd1;   end
        3: begin mem_a[idx] = 8'($urandom_range(0, 255));   mem_b[idx] = 8'($urandom_range(0, 255));   end
        default: begin mem_a[idx] = 8'($urandom_range(200, 255)); mem_b[idx] = 8'($urandom_range(200, 255)); end
      endcase
    end
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int s;
        s = 0;
        for (int kk = 0; kk < 8; kk++) s += int'(mem_a[r*8+kk]) * int'(mem_b[kk*8+c]);
        model_c[r*8+c] = s;
      end
    end
  endtask

  // mode 0: plain run; 1: start re-pulsed at cycle 100 and in the DONE cycle;
  // 2: reset at cycle 300 (run aborted).
  task automatic run(input int mode, input int exp_c0, input int exp_c63);
    bit finished;
    int rel;
    finished = 1'b0;
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_rel_q.delete();
    done_cnt = 0;
    done_rel = -1;
    busy_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    e0    = edge_cnt;
    start = 1'b0;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      rel   = edge_cnt - e0;
      start = 1'b0;
      if (mode == 1 && rel == 100) start = 1'b1;
      if (mode == 2 && rel == 299) reset = 1'b1;
      if (mode == 2 && rel == 300) begin
        reset = 1'b0;
        chk("abort_mwr_c", 64'(mwr_c), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        finished = 1'b1;
        break;
      end
      if (done === 1'b1) begin
        if (mode == 1) start = 1'b1;
        finished = 1'b1;
        break;
      end
    end
    chk("run_terminated", 64'(finished), 64'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    if (mode == 2) begin
      chk("abort_write_count", 64'(wr_addr_q.size()), 64'd30);
      chk("abort_done_count", 64'(done_cnt), 64'd0);
      chk("abort_busy_after", 64'(busy), 64'd0);
      for (int n = 0; n < wr_addr_q.size() && n < 30; n++) begin
        chk("abort_addr", 64'(wr_addr_q[n]), 64'(n));
        chk("abort_data", 64'(wr_data_q[n]), 64'(model_c[n]));
      end
    end else begin
      chk("write_count", 64'(wr_addr_q.size()), 64'd64);
      for (int n = 0; n < wr_addr_q.size() && n < 64; n++) begin
        chk("write_addr", 64'(wr_addr_q[n]), 64'(n));
        chk("write_data", 64'(wr_data_q[n]), 64'(model_c[n]));
        chk("write_cycle", 64'(wr_rel_q[n]), 64'(10*n + 9));
      end
      if (wr_data_q.size() == 64 && exp_c0 >= 0) begin
        chk("c_first_spot", 64'(wr_data_q[0]), 64'(exp_c0));
        chk("c_last_spot", 64'(wr_data_q[63]), 64'(exp_c63));
      end
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("done_cycle", 64'(done_rel), 64'd640);
      chk("busy_cycles", 64'(busy_cnt), 64'd640);
      chk("busy_after", 64'(busy), 64'd0);
      chk("mwr_c_after", 64'(mwr_c), 64'd0);
    end
  endtask

  typedef struct {
    int kind;
    int exp_c0;
    int exp_c63;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // kind 0: identity A, ramp B; 1: all 255; 2: all ones; 3/4: random.
    vecs[0] = '{0, 0, 63};
    vecs[1] = '{1, 520200, 520200};
    vecs[2] = '{2, 8, 8};
    vecs[3] = '{3, -1, -1};
    vecs[4] = '{4, -1, -1};
    vecs[5] = '{3, -1, -1};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_mwr_c", 64'(mwr_c), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start_busy", 64'(busy), 64'd0);

    for (int v = 0; v < 6; v++) begin
      load(vecs[v].kind);
      run(0, vecs[v].exp_c0, vecs[v].exp_c63);
    end

    // start while busy and during DONE must be ignored
    load(3);
    run(1, -1, -1);

    // reset mid-run, then a full clean run from element 0
    load(0);
    run(2, -1, -1);
    run(0, 0, 63);

    // reset and start together: stays idle
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("collision_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("collision_busy_later", 64'(busy), 64'd0);
    chk("collision_mwr_c", 64'(mwr_c), 64'd0);
    chk("collision_done", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
